// File: rtl/updown_seq_pkg.sv
// updown_seq_pkg: shared FSM state, run-mode and direction encodings for the count sequencer
package updown_seq_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/updown_count_sequencer_if.sv
// updown_count_sequencer_if: command/config inputs and count/status outputs of the sequencer
interface updown_count_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int PRESC_W = 8
);
  logic start;
  logic stop;
  logic [1:0] mode;
  logic dir_in;
  logic [WIDTH-1:0] limit;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0] count;
  logic dir_out;
  logic busy;
  logic done;
  logic wrap;
  modport master (
    output start, stop, mode, dir_in, limit, presc,
    input count, dir_out, busy, done, wrap
  );
  modport slave (
    input start, stop, mode, dir_in, limit, presc,
    output count, dir_out, busy, done, wrap
  );
endinterface

// File: rtl/count_prescaler.sv
// count_prescaler: divides clk so tick fires once every period+1 enabled cycles
module count_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic [PRESC_W-1:0] period,
  output logic tick
);
  logic [PRESC_W-1:0] cnt;
  assign tick = enable && cnt == period;
  // restart from zero on clear or on each tick, otherwise advance while enabled
  always_ff @(posedge clk) begin
    cnt <= (rst || clear || tick) ? '0 : enable ? cnt + 1'b1 : cnt;
  end
endmodule

// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer: runs a prescaled up/down count with one-shot, wrap or bounce at the terminal value
module updown_count_sequencer
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRESC_W = 8
) (
  input logic clk,
  input logic rst,
  updown_count_sequencer_if.slave bus
);
  state_t state;
  logic [1:0] mode_q;
  logic dir_q;
  logic [WIDTH-1:0] limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic [WIDTH-1:0] count_q;
  logic dir_r;
  logic busy_q;
  logic done_q;
  logic wrap_q;
  logic tick;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] reload;
  count_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk(clk),
    .rst(rst),
    .clear(state != RUN),
    .enable(state == RUN),
    .period(presc_q),
    .tick(tick)
  );
  assign term = dir_r == DIR_UP ? limit_q : '0;
  assign reload = dir_r == DIR_UP ? '0 : limit_q;
  assign bus.count = count_q;
  assign bus.dir_out = dir_r;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;
  // sequencing FSM with count register; stop outranks any coincident tick, pulses default low
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= '0;
      dir_q <= DIR_DOWN;
      limit_q <= '0;
      presc_q <= '0;
      count_q <= '0;
      dir_r <= DIR_DOWN;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            mode_q <= bus.mode;
            dir_q <= bus.dir_in;
            limit_q <= bus.limit;
            presc_q <= bus.presc;
            busy_q <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (bus.stop) begin
            busy_q <= 1'b0;
            state <= IDLE;
          end else begin
            count_q <= dir_q == DIR_UP ? '0 : limit_q;
            dir_r <= dir_q;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            busy_q <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            if (count_q != term) begin
              count_q <= dir_r == DIR_UP ? count_q + 1'b1 : count_q - 1'b1;
            end else if (mode_q == MODE_WRAP) begin
              count_q <= reload;
              wrap_q <= 1'b1;
            end else if (mode_q == MODE_BOUNCE) begin
              dir_r <= ~dir_r;
              wrap_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb_updown_count_sequencer: directed and randomized runs checked against a time-arithmetic reference model
module tb_updown_count_sequencer;
  localparam int W = 4;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_count;
  logic m_dir;
  updown_count_sequencer_if #(.WIDTH(W), .PRESC_W(PW)) bus ();
  updown_count_sequencer #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] c, input logic d, input logic b,
                            input logic dn, input logic w);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".dir"}, 32'(bus.dir_out), 32'(d));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".done"}, 32'(bus.done), 32'(dn));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble;
    bus.mode = 2'($urandom);
    bus.dir_in = 1'($urandom);
    bus.limit = W'($urandom);
    bus.presc = PW'($urandom);
  endtask

  // One run: edge 0 latches config, edge 1 is ARM, ticks land every p+1 edges after that.
  // stop_e / rst_e: edge index at which stop / rst is applied (0 = never).
  task automatic run(input logic [1:0] md, input logic dr, input logic [W-1:0] lim,
                     input logic [PW-1:0] p, input int stop_e, input int rst_e);
    logic [W-1:0] term;
    logic dn;
    logic w;
    bit fin;
    bit ended;
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.mode = md;
    bus.dir_in = dr;
    bus.limit = lim;
    bus.presc = p;
    step;
    expect_out("arm", m_count, m_dir, 1'b1, 1'b0, 1'b0);
    fin = 0;
    ended = 0;
    for (int e = 1; e < 400 && !ended; e++) begin
      bus.start = (e == rst_e) ? 1'b1 : 1'($urandom);
      scramble;
      bus.stop = (e == stop_e);
      rst = (e == rst_e);
      step;
      dn = 1'b0;
      w = 1'b0;
      if (e == rst_e) begin
        m_count = '0;
        m_dir = 1'b0;
        expect_out("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        ended = 1;
      end else if (fin) begin
        expect_out("post_done", m_count, m_dir, 1'b0, 1'b0, 1'b0);
        ended = 1;
      end else if (e == stop_e) begin
        expect_out("stop", m_count, m_dir, 1'b0, 1'b0, 1'b0);
        ended = 1;
      end else begin
        if (e == 1) begin
          m_count = dr ? '0 : lim;
          m_dir = dr;
        end else if ((e - 1) % (int'(p) + 1) == 0) begin
          term = m_dir ? lim : '0;
          if (m_count != term) m_count = m_dir ? m_count + 1'b1 : m_count - 1'b1;
          else if (md == 2'd1) begin
            m_count = m_dir ? '0 : lim;
            w = 1'b1;
          end else if (md == 2'd2) begin
            m_dir = ~m_dir;
            w = 1'b1;
          end else begin
            dn = 1'b1;
            fin = 1;
          end
        end
        expect_out("run", m_count, m_dir, !fin, dn, w);
      end
    end
    check("run_ended", 32'(ended), 32'd1);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    rst = 1'b0;
    step;
    expect_out("idle", m_count, m_dir, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = '0;
    bus.dir_in = 1'b0;
    bus.limit = '0;
    bus.presc = '0;
    rst = 1'b1;
    bus.start = 1'b1;
    step;
    step;
    m_count = '0;
    m_dir = 1'b0;
    expect_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    rst = 1'b0;
    step;
    expect_out("reset_idle", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2'd0, 1'b1, 4'd3, 8'd0, 0, 0);
    check("oneshot_final", 32'(bus.count), 32'd3);
    run(2'd1, 1'b0, 4'd2, 8'd1, 30, 0);
    run(2'd2, 1'b1, 4'd2, 8'd0, 20, 0);
    run(2'd0, 1'b1, 4'd7, 8'd0, 3, 0);
    check("stop_hold", 32'(bus.count), 32'd1);
    run(2'd0, 1'b1, 4'd7, 8'd0, 2, 0);
    check("rearm_zero", 32'(bus.count), 32'd0);
    run(2'd2, 1'b1, 4'd0, 8'd0, 10, 0);
    run(2'd0, 1'b1, 4'd0, 8'd0, 0, 0);
    run(2'd3, 1'b1, 4'd4, 8'd2, 0, 0);
    run(2'd0, 1'b0, 4'd5, 8'd1, 0, 0);
    run(2'd0, 1'b1, 4'd9, 8'd0, 0, 7);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step;
    expect_out("start_stop_idle", m_count, m_dir, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    for (int r = 0; r < 60; r++) begin
      logic [1:0] md;
      logic [PW-1:0] p;
      int se;
      int re;
      md = 2'($urandom);
      p = ($urandom_range(0, 3) != 0) ? PW'($urandom_range(0, 3)) : PW'($urandom_range(0, 15));
      se = $urandom_range(1, 120);
      if ((md == 2'd0 || md == 2'd3) && $urandom_range(0, 1) == 1) se = 0;
      re = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0;
      run(md, 1'($urandom), W'($urandom), p, se, re);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
